// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle RV32 control FSM.
// Contents: state encodings (also wrapped in state_t), the opcodes the FSM
// decodes, ALUOp codes for the ALU control decoder, and ALUSrcB selects.
package multicycle_control_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_FETCH     = 4'd1;
    localparam logic [3:0] ST_DECODE    = 4'd2;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd3;
    localparam logic [3:0] ST_MEM_READ  = 4'd4;
    localparam logic [3:0] ST_MEM_WB    = 4'd5;
    localparam logic [3:0] ST_MEM_WRITE = 4'd6;
    localparam logic [3:0] ST_EXEC_R    = 4'd7;
    localparam logic [3:0] ST_R_WB      = 4'd8;
    localparam logic [3:0] ST_BRANCH    = 4'd9;
    localparam logic [3:0] ST_TRAP      = 4'd10;

    typedef enum logic [3:0] {
        IDLE      = ST_IDLE,
        FETCH     = ST_FETCH,
        DECODE    = ST_DECODE,
        MEM_ADDR  = ST_MEM_ADDR,
        MEM_READ  = ST_MEM_READ,
        MEM_WB    = ST_MEM_WB,
        MEM_WRITE = ST_MEM_WRITE,
        EXEC_R    = ST_EXEC_R,
        R_WB      = ST_R_WB,
        BRANCH    = ST_BRANCH,
        TRAP      = ST_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32 datapath.
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives the datapath selects and write enables (Moore decode of the
// registered state). Counts retired instructions.
//
// Optional feature macro: MEM_HANDSHAKE_EN
//   defined   : FETCH, MEM_READ and MEM_WRITE wait for mem_ready=1; PCWrite
//               and IRWrite only pulse in the cycle the fetch completes.
//   undefined : mem_ready is ignored, every state lasts one cycle.
//
// Ports:
//   clk, reset (async, active-high)
//   opcode      : IR[6:0], sampled in DECODE and MEM_ADDR
//   mem_ready   : memory access complete (handshake builds only)
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   RegWrite, ALUSrcA, ALUSrcB[1:0], PCSource, ALUOp[1:0] : datapath controls
//   trap        : illegal opcode seen; held until reset
//   state[3:0]  : current FSM state, for debug
//   instr_count : retired-instruction counter, wraps silently
//
// Handshake semantics: with MEM_HANDSHAKE_EN, a memory state is "valid" while
// it is occupied and the access completes on the rising edge where mem_ready
// is 1; the state holds, outputs unchanged, for every cycle mem_ready is 0.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             PCSource,
    output logic [1:0]       ALUOp,
    output logic             trap,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    state_t state_q;
    state_t state_next;
    logic   mem_ok;
    logic   retire;

`ifdef MEM_HANDSHAKE_EN
    assign mem_ok = mem_ready;
`else
    logic mem_ready_unused;
    assign mem_ready_unused = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    assign state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next  = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RS2;
        PCSource    = 1'b0;
        ALUOp       = ALUOP_ADD;
        trap        = 1'b0;

        case (state_q)
            IDLE: state_next = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ALUOp   = ALUOP_ADD;
                // PC/IR load only once the fetched word is actually there.
                PCWrite = mem_ok;
                IRWrite = mem_ok;
                if (mem_ok) state_next = DECODE;
            end
            DECODE: begin
                // Branch target PC+imm lands in ALUOut for a possible beq.
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = MEM_ADDR;
                    OP_RTYPE:          state_next = EXEC_R;
                    OP_BRANCH:         state_next = BRANCH;
                    default:           state_next = TRAP;
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = ALUOP_ADD;
                state_next = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ok) state_next = MEM_WB;
            end
            MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                state_next = FETCH;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ok) state_next = FETCH;
            end
            EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_RS2;
                ALUOp      = ALUOP_FUNCT;
                state_next = R_WB;
            end
            R_WB: begin
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_RS2;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                state_next  = FETCH;
            end
            TRAP: trap = 1'b1;
            default: state_next = IDLE;
        endcase
    end

    // An instruction retires on the edge that leaves its final state.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            MEM_WB, R_WB, BRANCH: retire = 1'b1;
            MEM_WRITE:            retire = mem_ok;
            default:              retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int CW = 3;
    localparam int W  = 19 + CW;

    logic          clk;
    logic          reset;
    logic [6:0]    opcode;
    logic          mem_ready;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic          MemtoReg, RegWrite, ALUSrcA, PCSource, trap;
    logic [1:0]    ALUSrcB, ALUOp;
    logic [3:0]    state;
    logic [CW-1:0] instr_count;

    logic [W-1:0]  exp_q[$];
    logic [CW-1:0] exp_cnt;
    int            checks;
    int            errors;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .trap(trap),
        .state(state), .instr_count(instr_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for a state, straight from the state table.
    function automatic logic [W-1:0] exp_word(input logic [3:0] st,
                                              input logic [CW-1:0] cnt,
                                              input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, asa, pcs, trp;
        logic [1:0] asb, aop;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, asa, pcs, trp} = '0;
        asb = 2'b00;
        aop = 2'b00;
        case (st)
            4'd1:  begin mrd = 1; irw = mr; pcw = mr; asb = 2'b01; end
            4'd2:  asb = 2'b10;
            4'd3:  begin asa = 1; asb = 2'b10; end
            4'd4:  begin mrd = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mwr = 1; iord = 1; end
            4'd7:  begin asa = 1; aop = 2'b10; end
            4'd8:  rw = 1;
            4'd9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 1; end
            4'd10: trp = 1;
            default: ;
        endcase
        return {st, pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, asa, asb, pcs, aop, trp, cnt};
    endfunction

    function automatic logic [W-1:0] act_word();
        return {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, trap, instr_count};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // scoreboard monitor: one expected control word per cycle
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("ctrl_st%0d", e[W-1 -: 4]), 64'(act_word()), 64'(e));
        end
    end

    // driver tasks
    task automatic cyc(input logic [3:0] st);
        logic mr;
`ifdef MEM_HANDSHAKE_EN
        mr = mem_ready;
`else
        mr = 1'b1;
`endif
        exp_q.push_back(exp_word(st, exp_cnt, mr));
        @(posedge clk);
        #1;
    endtask

    task automatic do_ld();
        opcode = 7'b0000011;
        cyc(1); cyc(2); cyc(3); cyc(4); cyc(5);
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic do_sd();
        opcode = 7'b0100011;
        cyc(1); cyc(2); cyc(3); cyc(6);
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic do_r();
        opcode = 7'b0110011;
        cyc(1); cyc(2); cyc(7); cyc(8);
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic do_beq();
        opcode = 7'b1100011;
        cyc(1); cyc(2); cyc(9);
        exp_cnt = exp_cnt + 1'b1;
    endtask

    // Asserts reset mid-cycle and checks the asynchronous clear before any edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check({tag, "_state"}, 64'(state), 64'd0);
        check({tag, "_count"}, 64'(instr_count), 64'd0);
        check({tag, "_trap"}, 64'(trap), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_cnt = '0;
        cyc(0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_cnt   = '0;
        reset     = 1'b1;
        opcode    = 7'd0;
        mem_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_word", 64'(act_word()), 64'(exp_word(4'd0, 3'd0, 1'b1)));
        reset = 1'b0;
        cyc(0);

        do_ld();                              // count 1
`ifndef MEM_HANDSHAKE_EN
        mem_ready = 1'b0;                     // must be ignored
`endif
        do_r(); do_r(); do_r();               // count 4
        mem_ready = 1'b1;
        do_beq();                             // count 5
        do_sd();                              // count 6
        do_r();                               // count 7
        do_r();                               // wraps to 0

        // abort an R-type in EXEC_R; no retire
        opcode = 7'b0110011;
        cyc(1); cyc(2);
        exp_q.push_back(exp_word(4'd7, exp_cnt, 1'b1));
        pulse_reset("abort");

`ifdef MEM_HANDSHAKE_EN
        mem_ready = 1'b0;
        opcode    = 7'b0100011;
        cyc(1); cyc(1);
        mem_ready = 1'b1;
        cyc(1); cyc(2); cyc(3);
        mem_ready = 1'b0;
        cyc(6); cyc(6); cyc(6);
        mem_ready = 1'b1;
        cyc(6);
        exp_cnt = exp_cnt + 1'b1;
`endif

        // illegal opcode: trap holds with no write enables, count frozen
        opcode = 7'b1111111;
        cyc(1); cyc(2);
        repeat (20) cyc(10);
        pulse_reset("trap_clr");
        cyc(1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
